uart_tx_fifo: RTL and testbench

UART transmitter for the RV32I SoC. It is the transmit-side counterpart of the program-load receiver on `rx`, and it drives the SoC `tx` pin. Bytes are written from the core/bus side through a valid/ready port into a small FIFO. They are serialised as 8N1 frames, LSB first, at `CLKS_PER_BIT` clocks per bit. The default of 868 gives 115200 baud at 100 MHz, matching the loader's bit timing.

---
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a valid/ready write port through a circular FIFO
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PEN = BW'(CLKS_PER_BIT - 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q;
  logic [BW-1:0]    baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_q, busy_q, done_q, ready_q, empty_q;
  logic             push, pop, bit_end;
  always_comb begin
    bit_end = baud_q == BAUD_LAST;
    push = wr_valid && ready_q;
    pop = !empty_q && (state_q == IDLE || (state_q == STOP && bit_end));
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      empty_q <= count_d == '0;
      ready_q <= count_d != CNT_W'(FIFO_DEPTH);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // registered one cycle ahead so the pulse lands on the last stop-bit cycle
      done_q <= state_q == STOP && baud_q == BAUD_PEN;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          shift_q <= mem_q[rd_ptr_q];
          tx_q <= 1'b0;
          busy_q <= 1'b1;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          bit_q <= '0;
          tx_q <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        DATA: if (bit_end) begin
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end else begin
            tx_q <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        default: if (bit_end) begin
          if (pop) begin
            state_q <= START;
            shift_q <= mem_q[rd_ptr_q];
            tx_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end
  assign wr_ready = ready_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign tx_done = done_q;
  assign fifo_count = count_q;
  assign fifo_empty = empty_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter configurations checked each cycle against a queue/frame-time model
module tb_uart_tx_fifo;
  localparam int N = 4;
  function automatic int cpb(input int i);
    return i == 0 ? 868 : (i == 3 ? 2 : 4);
  endfunction
  function automatic int dep(input int i);
    return i == 2 ? 4 : (i == 3 ? 2 : 16);
  endfunction
  logic clk = 1'b0;
  logic rst_r[N], wr_valid_r[N], wr_ready_w[N], tx_w[N], busy_w[N], done_w[N], empty_w[N];
  logic [7:0] wr_data_r[N];
  logic [4:0] cnt_w[N];
  logic [7:0] mq[N][$];
  logic [7:0] exp_q[N][$];
  int falls[N][$];
  int ft[N], dt[N], fall_c[N], peak[N], rst_at[N];
  logic [7:0] cur[N];
  logic [9:0] bits_q[N];
  bit known[N];
  bit fin, acc, pop;
  int pcyc, cyc, k, e, t;
  int n_cmp, n_bad;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [$clog2(dep(g)):0] c;
    uart_tx_fifo #(.CLKS_PER_BIT(cpb(g)), .FIFO_DEPTH(dep(g))) u (
      .clk(clk), .rst(rst_r[g]), .wr_data(wr_data_r[g]), .wr_valid(wr_valid_r[g]),
      .wr_ready(wr_ready_w[g]), .tx(tx_w[g]), .busy(busy_w[g]), .tx_done(done_w[g]),
      .fifo_count(c), .fifo_empty(empty_w[g])
    );
    assign cnt_w[g] = 5'(c);
  end
  task automatic chk(input int i, input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", nm, i, cyc, act, req);
    end
  endtask
  // ft = cycles into the current frame, -1 when idle
  function automatic int m_tx(input int i);
    if (ft[i] < 0 || ft[i] >= 9 * cpb(i)) return 1;
    if (ft[i] < cpb(i)) return 0;
    return int'((cur[i] >> (ft[i] / cpb(i) - 1)) & 8'd1);
  endfunction
  always @(posedge clk) begin
    pcyc++;
    for (int i = 0; i < N; i++) begin
      if (rst_r[i]) begin
        mq[i].delete();
        ft[i] = -1;
        known[i] = 1'b1;
        rst_at[i] = pcyc;
      end else if (known[i]) begin
        fin = ft[i] == 10 * cpb(i) - 1;
        acc = wr_valid_r[i] && mq[i].size() < dep(i);
        pop = (ft[i] < 0 || fin) && mq[i].size() > 0;
        if (pop) begin
          cur[i] = mq[i].pop_front();
          ft[i] = 0;
        end else if (fin) ft[i] = -1;
        else if (ft[i] >= 0) ft[i]++;
        if (acc) mq[i].push_back(wr_data_r[i]);
      end
    end
  end
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (known[i]) begin
        chk(i, "tx", int'(tx_w[i]), m_tx(i));
        chk(i, "busy", int'(busy_w[i]), int'(ft[i] >= 0));
        chk(i, "tx_done", int'(done_w[i]), int'(ft[i] == 10 * cpb(i) - 1));
        chk(i, "fifo_count", int'(cnt_w[i]), mq[i].size());
        chk(i, "fifo_empty", int'(empty_w[i]), int'(mq[i].size() == 0));
        chk(i, "wr_ready", int'(wr_ready_w[i]), int'(mq[i].size() < dep(i)));
        if (int'(cnt_w[i]) > peak[i]) peak[i] = int'(cnt_w[i]);
      end
      // independent line decoder sampling mid-bit
      if (rst_at[i] == pcyc) dt[i] = -1;
      else if (dt[i] >= 0) dt[i]++;
      else if (!tx_w[i]) begin
        dt[i] = 0;
        fall_c[i] = cyc;
        falls[i].push_back(cyc);
      end
      if (dt[i] >= 0 && dt[i] % cpb(i) == cpb(i) / 2) begin
        k = dt[i] / cpb(i);
        bits_q[i] = k == 0 ? 10'(tx_w[i]) : bits_q[i] | (10'(tx_w[i]) << k);
        if (k == 0) chk(i, "start_bit", int'(tx_w[i]), 0);
        if (k == 9) begin
          chk(i, "stop_bit", int'(tx_w[i]), 1);
          e = exp_q[i].size() != 0 ? int'(exp_q[i].pop_front()) : -1;
          chk(i, "rx_byte", int'(bits_q[i][8:1]), e);
          dt[i] = -1;
        end
      end
      if (done_w[i]) chk(i, "frame_len", cyc - fall_c[i] + 1, i == 0 ? 8680 : 10 * cpb(i));
    end
  end
  task automatic send(input int i, input logic [7:0] d);
    int w;
    w = 0;
    wr_valid_r[i] = 1'b1;
    wr_data_r[i] = d;
    while (!wr_ready_w[i] && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk(i, "wr_ready_wait", int'(wr_ready_w[i]), 1);
    exp_q[i].push_back(d);
    @(negedge clk);
    wr_valid_r[i] = 1'b0;
    wr_data_r[i] = 8'($urandom);
  endtask
  task automatic drain(input int i);
    int w;
    w = 0;
    while ((exp_q[i].size() != 0 || busy_w[i]) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk(i, "drained", exp_q[i].size() + int'(busy_w[i]), 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      rst_r[i] = 1'b1;
      wr_valid_r[i] = 1'b0;
      wr_data_r[i] = 8'h00;
      dt[i] = -1;
      rst_at[i] = -1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) rst_r[i] = 1'b0;
    repeat (100) @(negedge clk);
    chk(0, "idle_tx", int'(tx_w[0]), 1);
    chk(0, "idle_wr_ready", int'(wr_ready_w[0]), 1);
    chk(0, "idle_empty", int'(empty_w[0]), 1);
    chk(0, "idle_busy", int'(busy_w[0]), 0);
    chk(0, "idle_count", int'(cnt_w[0]), 0);
    send(0, 8'hA5);
    chk(0, "tx_before_fall", int'(tx_w[0]), 1);
    @(negedge clk);
    chk(0, "tx_fall", int'(tx_w[0]), 0);
    drain(0);
    chk(0, "a5_bits", int'(bits_q[0]), 'h34A);
    chk(0, "busy_after", int'(busy_w[0]), 0);
    falls[1].delete();
    send(1, 8'h00);
    send(1, 8'hFF);
    send(1, 8'h55);
    chk(1, "b2b_peak_count", int'(cnt_w[1]), 2);
    drain(1);
    chk(1, "b2b_gap1", falls[1][1] - falls[1][0], 40);
    chk(1, "b2b_gap2", falls[1][2] - falls[1][1], 40);
    peak[1] = 0;
    for (int b = 0; b < 20; b++) send(1, 8'(b));
    drain(1);
    chk(1, "full_peak", peak[1], 16);
    send(2, 8'h10);
    for (int b = 1; b < 32; b++) begin
      t = 0;
      while (!done_w[2] && t < 1000) begin
        @(negedge clk);
        t++;
      end
      chk(2, "tx_done_wait", int'(done_w[2]), 1);
      send(2, 8'(16 + b));
    end
    drain(2);
    send(1, 8'h3C);
    send(1, 8'h5A);
    send(1, 8'h96);
    t = 0;
    while (dt[1] < 21 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(1, "reach_bit4", int'(dt[1] >= 21), 1);
    exp_q[1].delete();
    rst_r[1] = 1'b1;
    @(negedge clk);
    rst_r[1] = 1'b0;
    chk(1, "rst_tx", int'(tx_w[1]), 1);
    chk(1, "rst_count", int'(cnt_w[1]), 0);
    chk(1, "rst_busy", int'(busy_w[1]), 0);
    send(1, 8'hC3);
    drain(1);
    for (int i = 1; i < N; i++) begin
      for (int n = 0; n < 50; n++) begin
        repeat ($urandom_range(0, n % 3 == 0 ? 60 : 3)) @(negedge clk);
        send(i, 8'($urandom));
      end
      drain(i);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
